// File: rtl/lsu_mem_port.sv
// Load/store initiator: byte-addressed RV32 load/store to a word-addressed data memory.
// Latency: legal command 2 cycles from accept to rsp_valid pulse; illegal command 1 cycle.
// Backpressure: cmd_ready is high only in IDLE; one command per 3 cycles (2 when rejected), nothing queued.
module lsu_mem_port #(
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_store,
    input  logic [2:0]        i_cmd_funct3,
    input  logic [31:0]       i_cmd_addr,
    input  logic [31:0]       i_cmd_wdata,
    output logic              o_rsp_valid,
    output logic [31:0]       o_rsp_rdata,
    output logic              o_rsp_err,
    output logic              o_mem_request,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic [31:0]       o_mem_w_data,
    output logic [3:0]        o_mem_masking,
    output logic              o_mem_we_re,
    input  logic [31:0]       i_mem_r_data
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_cmd_ready;
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_rdata;
    logic              r_rsp_err;
    logic              r_mem_request;
    logic [ADDR_W-1:0] r_mem_address;
    logic [31:0]       r_mem_w_data;
    logic [3:0]        r_mem_masking;
    logic              r_mem_we_re;
    logic              r_store;
    logic [2:0]        r_funct3;
    logic [1:0]        r_lane;

    logic [31:0]       w_addr_hi;
    logic              w_oor;
    logic              w_f3_ok;
    logic              w_aligned;
    logic              w_legal;
    logic [31:0]       w_lanes;
    logic [3:0]        w_mask;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load_data;

    // Any address bit above the memory's byte range makes the access out of range.
    assign w_addr_hi = i_cmd_addr >> (ADDR_W + 2);
    assign w_oor     = |w_addr_hi;

    // Decode the incoming command: legality, store lane replication and byte-write mask.
    // These only feed registers, so mem_* never sees a combinational path from cmd_*.
    always_comb begin
        w_f3_ok   = 1'b1;
        w_aligned = 1'b1;
        w_lanes   = 32'h0;
        w_mask    = 4'b0000;
        case ({i_cmd_store, i_cmd_funct3})
            4'b1_000: begin
                w_lanes = {4{i_cmd_wdata[7:0]}};
                w_mask  = 4'b0001 << i_cmd_addr[1:0];
            end
            4'b1_001: begin
                w_aligned = ~i_cmd_addr[0];
                w_lanes   = {2{i_cmd_wdata[15:0]}};
                w_mask    = i_cmd_addr[1] ? 4'b1100 : 4'b0011;
            end
            4'b1_010: begin
                w_aligned = (i_cmd_addr[1:0] == 2'b00);
                w_lanes   = i_cmd_wdata;
                w_mask    = 4'b1111;
            end
            4'b0_000, 4'b0_100: w_aligned = 1'b1;
            4'b0_001, 4'b0_101: w_aligned = ~i_cmd_addr[0];
            4'b0_010:           w_aligned = (i_cmd_addr[1:0] == 2'b00);
            default:            w_f3_ok   = 1'b0;
        endcase
        w_legal = w_f3_ok & w_aligned & ~w_oor;
    end

    // Pick the addressed byte/halfword out of the read word and extend it per the load type.
    always_comb begin
        case (r_lane)
            2'd0:    w_byte = i_mem_r_data[7:0];
            2'd1:    w_byte = i_mem_r_data[15:8];
            2'd2:    w_byte = i_mem_r_data[23:16];
            default: w_byte = i_mem_r_data[31:24];
        endcase
        w_half = r_lane[1] ? i_mem_r_data[31:16] : i_mem_r_data[15:0];
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_data = {24'h0, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b101:  w_load_data = {16'h0, w_half};
            default: w_load_data = i_mem_r_data;
        endcase
    end

    // Control FSM; every output is a register so reset clears them asynchronously,
    // which also kills an in-flight write before the next edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_cmd_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= 32'h0;
            r_rsp_err     <= 1'b0;
            r_mem_request <= 1'b0;
            r_mem_address <= '0;
            r_mem_w_data  <= 32'h0;
            r_mem_masking <= 4'b0000;
            r_mem_we_re   <= 1'b1;
            r_store       <= 1'b0;
            r_funct3      <= 3'b000;
            r_lane        <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        r_store     <= i_cmd_store;
                        r_funct3    <= i_cmd_funct3;
                        r_lane      <= i_cmd_addr[1:0];
                        if (w_legal) begin
                            r_state       <= S_ACCESS;
                            r_mem_request <= 1'b1;
                            r_mem_address <= i_cmd_addr[ADDR_W+1:2];
                            r_mem_we_re   <= ~i_cmd_store;
                            r_mem_masking <= i_cmd_store ? w_mask : 4'b0000;
                            r_mem_w_data  <= i_cmd_store ? w_lanes : 32'h0;
                        end else begin
                            // Rejected: skip memory entirely and respond next cycle.
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= 32'h0;
                        end
                    end
                end
                S_ACCESS: begin
                    r_state       <= S_RESP;
                    r_mem_request <= 1'b0;
                    r_mem_we_re   <= 1'b1;
                    r_mem_masking <= 4'b0000;
                    r_mem_w_data  <= 32'h0;
                    r_rsp_valid   <= 1'b1;
                    r_rsp_err     <= 1'b0;
                    r_rsp_rdata   <= r_store ? 32'h0 : w_load_data;
                end
                S_RESP: begin
                    // rsp_rdata/rsp_err stay as they are until the next response.
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_cmd_ready <= 1'b1;
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_cmd_ready   <= 1'b1;
                    r_rsp_valid   <= 1'b0;
                    r_mem_request <= 1'b0;
                    r_mem_we_re   <= 1'b1;
                    r_mem_masking <= 4'b0000;
                    r_mem_w_data  <= 32'h0;
                end
            endcase
        end
    end

    assign o_cmd_ready   = r_cmd_ready;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_rdata   = r_rsp_rdata;
    assign o_rsp_err     = r_rsp_err;
    assign o_mem_request = r_mem_request;
    assign o_mem_address = r_mem_address;
    assign o_mem_w_data  = r_mem_w_data;
    assign o_mem_masking = r_mem_masking;
    assign o_mem_we_re   = r_mem_we_re;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: directed test-plan steps plus random commands vs a byte-array model.
// Memory is a word array written on posedge when request=1 and we_re=0, read combinationally.
// Outputs are sampled on the falling edge; inputs are driven on the falling edge.
module tb_lsu_mem_port;

    localparam int ADDR_W    = 8;
    localparam int WORDS     = 1 << ADDR_W;
    localparam int MEM_BYTES = 4 * WORDS;

    logic              clk;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_store;
    logic [2:0]        cmd_funct3;
    logic [31:0]       cmd_addr;
    logic [31:0]       cmd_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              mem_request;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_w_data;
    logic [3:0]        mem_masking;
    logic              mem_we_re;
    logic [31:0]       mem_r_data;

    logic [31:0] mem [0:WORDS-1];
    logic        mem_init;
    logic [7:0]  ref_b [0:MEM_BYTES-1];

    int total = 0;
    int bad   = 0;

    lsu_mem_port #(.ADDR_W(ADDR_W)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_cmd_valid  (cmd_valid),
        .o_cmd_ready  (cmd_ready),
        .i_cmd_store  (cmd_store),
        .i_cmd_funct3 (cmd_funct3),
        .i_cmd_addr   (cmd_addr),
        .i_cmd_wdata  (cmd_wdata),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_rdata  (rsp_rdata),
        .o_rsp_err    (rsp_err),
        .o_mem_request(mem_request),
        .o_mem_address(mem_address),
        .o_mem_w_data (mem_w_data),
        .o_mem_masking(mem_masking),
        .o_mem_we_re  (mem_we_re),
        .i_mem_r_data (mem_r_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int w);
        return 32'(w + 1) * 32'h9E3779B9;
    endfunction

    // Memory under the DUT.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int w = 0; w < WORDS; w++) mem[w] <= init_word(w);
        end else if (mem_request && !mem_we_re) begin
            for (int i = 0; i < 4; i++)
                if (mem_masking[i]) mem[mem_address][8*i +: 8] <= mem_w_data[8*i +: 8];
        end
    end
    assign mem_r_data = mem[mem_address];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Access size in bytes for a command, 0 if the size code is not defined.
    function automatic int size_of(input logic st, input logic [2:0] f3);
        if (st) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit is_legal(input logic st, input logic [2:0] f3, input logic [31:0] a);
        int sz;
        sz = size_of(st, f3);
        return (sz != 0) && ((a % sz) == 0) && (a < MEM_BYTES);
    endfunction

    // Little-endian gather from the byte model, then extend.
    function automatic logic [31:0] load_exp(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v;
        int sz;
        sz = size_of(1'b0, f3);
        v  = 32'h0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_b[int'(a) + i];
        if (sz < 4 && !f3[2] && v[8*sz-1])
            for (int i = sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [31:0] ref_word(input int w);
        return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
    endfunction

    // Issue one command and check every phase of its handshake.
    task automatic run_cmd(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, output logic [31:0] rd);
        int          sz;
        bit          legal;
        int          waitc;
        logic [31:0] exp_rd;
        logic [3:0]  exp_m;
        logic [31:0] exp_wd;
        int          base;
        sz     = size_of(st, f3);
        legal  = is_legal(st, f3, a);
        exp_rd = (legal && !st) ? load_exp(f3, a) : 32'h0;
        base   = int'(a & 32'hFFFF_FFFC);
        exp_m  = 4'b0000;
        exp_wd = 32'h0;
        if (st && legal) begin
            for (int i = 0; i < 4; i++) begin
                if (base + i >= int'(a) && base + i < int'(a) + sz) exp_m[i] = 1'b1;
                exp_wd[8*i +: 8] = d[8*(i % sz) +: 8];
            end
        end
        @(negedge clk);
        waitc = 0;
        while (!cmd_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        chk("cmd_ready_before", {31'h0, cmd_ready}, 32'h1);
        cmd_store  = st;
        cmd_funct3 = f3;
        cmd_addr   = a;
        cmd_wdata  = d;
        cmd_valid  = 1'b1;
        @(negedge clk);
        cmd_valid  = 1'b0;
        cmd_store  = 1'($urandom);
        cmd_funct3 = 3'($urandom);
        cmd_addr   = $urandom;
        cmd_wdata  = $urandom;
        chk("cmd_ready_busy", {31'h0, cmd_ready}, 32'h0);
        if (legal) begin
            chk("access_request", {31'h0, mem_request}, 32'h1);
            chk("access_address", 32'(mem_address), (a >> 2) & 32'(WORDS - 1));
            chk("access_we_re",   {31'h0, mem_we_re}, {31'h0, ~st});
            chk("access_masking", {28'h0, mem_masking}, {28'h0, exp_m});
            if (st) chk("access_w_data", mem_w_data, exp_wd);
            chk("access_rsp_idle", {31'h0, rsp_valid}, 32'h0);
            @(negedge clk);
            chk("resp_request_low", {31'h0, mem_request}, 32'h0);
            chk("resp_masking_zero", {28'h0, mem_masking}, 32'h0);
            chk("resp_we_re_read", {31'h0, mem_we_re}, 32'h1);
        end else begin
            chk("err_request_low", {31'h0, mem_request}, 32'h0);
        end
        chk("rsp_valid", {31'h0, rsp_valid}, 32'h1);
        chk("rsp_err",   {31'h0, rsp_err}, {31'h0, ~legal});
        chk("rsp_rdata", rsp_rdata, exp_rd);
        rd = rsp_rdata;
        @(negedge clk);
        chk("rsp_pulse_end", {31'h0, rsp_valid}, 32'h0);
        chk("cmd_ready_back", {31'h0, cmd_ready}, 32'h1);
        chk("rsp_rdata_held", rsp_rdata, exp_rd);
        if (st && legal)
            for (int i = 0; i < sz; i++) ref_b[int'(a) + i] = d[8*i +: 8];
    endtask

    initial begin : main
        logic [31:0] rd;
        logic [31:0] exp_a;
        logic [31:0] a;
        logic [2:0]  f3;
        logic        st;
        int          cnt;
        int          seen;
        int          badw;

        rst_n      = 1'b0;
        mem_init   = 1'b1;
        cmd_valid  = 1'b0;
        cmd_store  = 1'b0;
        cmd_funct3 = 3'd0;
        cmd_addr   = 32'h0;
        cmd_wdata  = 32'h0;
        for (int w = 0; w < WORDS; w++)
            for (int i = 0; i < 4; i++) ref_b[4*w+i] = init_word(w)[8*i +: 8];
        @(negedge clk);
        @(negedge clk);

        // Reset values.
        chk("reset_cmd_ready",   {31'h0, cmd_ready}, 32'h1);
        chk("reset_rsp_valid",   {31'h0, rsp_valid}, 32'h0);
        chk("reset_rsp_rdata",   rsp_rdata, 32'h0);
        chk("reset_rsp_err",     {31'h0, rsp_err}, 32'h0);
        chk("reset_mem_request", {31'h0, mem_request}, 32'h0);
        chk("reset_mem_we_re",   {31'h0, mem_we_re}, 32'h1);
        chk("reset_mem_masking", {28'h0, mem_masking}, 32'h0);
        chk("reset_mem_w_data",  mem_w_data, 32'h0);
        chk("reset_mem_address", 32'(mem_address), 32'h0);
        mem_init = 1'b0;
        rst_n    = 1'b1;

        // Directed test-plan steps.
        run_cmd(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, rd);
        run_cmd(1'b0, 3'd2, 32'h10, 32'h0, rd);
        chk("lw_after_sw", rd, 32'hDEADBEEF);
        run_cmd(1'b1, 3'd0, 32'h13, 32'h000000A5, rd);
        run_cmd(1'b0, 3'd0, 32'h13, 32'h0, rd);
        chk("lb_0x13", rd, 32'hFFFFFFA5);
        run_cmd(1'b0, 3'd4, 32'h13, 32'h0, rd);
        chk("lbu_0x13", rd, 32'h000000A5);
        run_cmd(1'b0, 3'd2, 32'h10, 32'h0, rd);
        chk("lw_after_sb", rd, 32'hA5ADBEEF);
        run_cmd(1'b1, 3'd1, 32'h12, 32'h00008001, rd);
        run_cmd(1'b0, 3'd1, 32'h12, 32'h0, rd);
        chk("lh_0x12", rd, 32'hFFFF8001);
        run_cmd(1'b0, 3'd5, 32'h12, 32'h0, rd);
        chk("lhu_0x12", rd, 32'h00008001);
        run_cmd(1'b0, 3'd2, 32'h11, 32'h0, rd);
        run_cmd(1'b1, 3'd1, 32'h01, 32'hCAFEF00D, rd);
        run_cmd(1'b0, 3'd0, 32'h400, 32'h0, rd);
        run_cmd(1'b0, 3'd3, 32'h10, 32'h0, rd);
        run_cmd(1'b1, 3'd4, 32'h14, 32'h11223344, rd);

        // Back-to-back: cmd_valid held through the busy cycles of the first load.
        @(negedge clk);
        cmd_store  = 1'b0;
        cmd_funct3 = 3'd2;
        cmd_addr   = 32'h10;
        cmd_valid  = 1'b1;
        exp_a      = load_exp(3'd2, 32'h10);
        @(negedge clk);
        cmd_funct3 = 3'd4;
        cmd_addr   = 32'h12;
        cnt  = 1;
        seen = 0;
        while (!cmd_ready && cnt < 10) begin
            if (rsp_valid) begin
                seen++;
                chk("b2b_first_rdata", rsp_rdata, exp_a);
            end
            @(negedge clk);
            cnt++;
        end
        chk("b2b_accept_gap", 32'(cnt), 32'd3);
        chk("b2b_first_rsp_count", 32'(seen), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("b2b_second_access", {31'h0, mem_request}, 32'h1);
        @(negedge clk);
        chk("b2b_second_rsp", {31'h0, rsp_valid}, 32'h1);
        chk("b2b_second_rdata", rsp_rdata, load_exp(3'd4, 32'h12));

        // Random commands, mostly legal, some misaligned, bad-size or out of range.
        for (int n = 0; n < 120; n++) begin
            st = 1'($urandom);
            case ($urandom_range(0, 9))
                0:       f3 = 3'($urandom);
                default: f3 = st ? 3'($urandom_range(0, 2))
                                 : ($urandom_range(0, 1) ? 3'($urandom_range(0, 2))
                                                         : 3'($urandom_range(4, 5)));
            endcase
            a = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 5) != 0) a = a & ~32'(size_of(st, f3) > 1 ? size_of(st, f3) - 1 : 0);
            if ($urandom_range(0, 15) == 0) a = a | (32'h1 << $urandom_range(10, 31));
            run_cmd(st, f3, a, $urandom, rd);
        end

        // Reset during ACCESS of a store: the write must not happen.
        @(negedge clk);
        cmd_store  = 1'b1;
        cmd_funct3 = 3'd2;
        cmd_addr   = 32'h20;
        cmd_wdata  = 32'h12345678;
        cmd_valid  = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("rst_mid_access_req", {31'h0, mem_request}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_request", {31'h0, mem_request}, 32'h0);
        chk("rst_async_ready",   {31'h0, cmd_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid) seen++;
            @(negedge clk);
        end
        chk("rst_no_rsp", 32'(seen), 32'd0);
        chk("rst_ready_after", {31'h0, cmd_ready}, 32'h1);
        chk("rst_word8_unchanged", mem[8], ref_word(8));

        // Whole memory against the byte model.
        badw = 0;
        for (int w = 0; w < WORDS; w++) if (mem[w] !== ref_word(w)) badw++;
        chk("memory_contents", 32'(badw), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop guard against a hang.
    initial begin
        #500000;
        $display("FAIL timeout: bench did not reach the end");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store initiator that sits between the core's execute stage and the word-addressed data memory. It accepts one byte-addressed RV32 load or store command per transaction. For stores it places the data on the correct byte lanes and generates the byte-write mask; for loads it extracts the addressed byte or halfword and sign- or zero-extends it. It also flags misaligned, out-of-range and illegal-size accesses without touching memory.

## Interface
- ADDR_W, 8, memory word-address width; the memory holds 2^ADDR_W 32-bit words (4·2^ADDR_W bytes).
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present; sampled only while cmd_ready=1.
- cmd_ready  out  1  high in IDLE only.
- cmd_store  in  1  1 = store, 0 = load.
- cmd_funct3  in  3  RV32 size code: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
- cmd_addr  in  32  byte address.
- cmd_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load result; 0 for stores and errors.
- rsp_err  out  1  qualifies rsp_valid; access was rejected.
- mem_request  out  1  memory access enable.
- mem_address  out  ADDR_W  word address = cmd_addr[ADDR_W+1:2].
- mem_w_data  out  32  lane-replicated store data.
- mem_masking  out  4  byte-write enables; bit i enables byte lane i.
- mem_we_re  out  1  0 = write, 1 = read. A write occurs at a clock edge when mem_request=1 and mem_we_re=0.
- mem_r_data  in  32  combinational read data for the current mem_address.

## Operation
- FSM states: IDLE, ACCESS, RESP.
  - In IDLE, cmd_valid=1 registers all cmd_* fields. The core may change cmd_* after acceptance.
  - A legal command goes IDLE→ACCESS→RESP→IDLE.
  - An illegal command goes IDLE→RESP→IDLE with rsp_err=1 and makes no memory access.
- A command is illegal if any of the following holds:
  - cmd_funct3 is not listed for its direction.
  - It is a halfword access with addr[0]=1.
  - It is a word access with addr[1:0]≠00.
  - addr[31:ADDR_W+2] is nonzero (out of range).
- ACCESS outputs: mem_request=1, mem_address from the registered address, mem_we_re=~store.
- Store lanes (b = addr[1:0]):
  - SB: w_data={4{d[7:0]}}, masking=0001<<b.
  - SH: w_data={2{d[15:0]}}, masking=addr[1]?1100:0011.
  - SW: w_data=d, masking=1111.
- Loads: masking=0000.
  - mem_r_data is captured at the edge ending ACCESS.
  - The byte or halfword at lane b (or addr[1]) is selected.
  - It is sign-extended for LB/LH and zero-extended for LBU/LHU; LW passes the word unchanged.
- Outside ACCESS: mem_request=0, mem_we_re=1, mem_masking=0, mem_w_data=0. No spurious writes can occur.
- rsp_valid=1 only in RESP. rsp_rdata and rsp_err are held until the next RESP and are not cleared in IDLE.

## Timing
- Reset values: state IDLE, cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_request=0, mem_we_re=1, mem_masking=0, mem_w_data=0, mem_address=0.
- Legal command accepted at edge N:
  - ACCESS occupies cycle N..N+1; a store writes memory at edge N+1.
  - rsp_valid is high for cycle N+1..N+2.
  - cmd_ready returns at N+2, so the next accept is at N+3.
  - Throughput is one command per 3 cycles.
- Illegal command accepted at edge N: rsp_valid=1, rsp_err=1 for cycle N..N+1; the next accept is at N+2.
- cmd_valid while cmd_ready=0 is ignored and not queued; the core holds it.
- rst_n low at any time forces reset values immediately, including mid-ACCESS. mem_request drops asynchronously, so no write occurs at the following edge. An in-flight load produces no rsp_valid.
- All mem_* outputs are registered or decoded from registered state only, with no combinational path from cmd_* to mem_*.

## Test plan
- SW addr 0x0000_0010, data 0xDEADBEEF:
  - ACCESS shows mem_address=0x04, masking=1111, we_re=0.
  - rsp_valid follows 1 cycle later with rsp_err=0.
  - A subsequent LW 0x10 returns 0xDEADBEEF.
- SB addr 0x13, data 0x000000A5:
  - w_data=0xA5A5A5A5, masking=1000.
  - With word 4 = 0xDEADBEEF: LB 0x13 returns 0xFFFFFFA5, LBU 0x13 returns 0x000000A5, LW 0x10 returns 0xA5ADBEEF.
- SH addr 0x12, data 0x00008001:
  - masking=1100.
  - LH 0x12 returns 0xFFFF8001, LHU 0x12 returns 0x00008001.
- Errors, each giving rsp_err=1 with rsp_valid one cycle after accept, mem_request never high, and memory contents unchanged:
  - LW 0x11.
  - SH 0x01.
  - LB 0x400 (ADDR_W=8).
  - Load funct3=011.
- Back-to-back commands:
  - cmd_valid held high with two loads: accepts at edges N and N+3.
  - Second command's cmd_ready=0 cycles are ignored.
- Reset mid-store: assert rst_n=0 during ACCESS of SW 0x20 data 0x12345678 → mem_request drops immediately, word 8 is unchanged, no rsp_valid, cmd_ready=1 after release.
